// File: rtl/proj_scan_ctrl.sv
// Sequencer sweeping FM buffers in order, issuing (buffer, index) read beats for the projection datapath.
// Latency: first beat one cycle after an accepted start; one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds the current beat and all flags stable; abort wins in every state.
module proj_scan_ctrl #(
    parameter int FM_BUFFER_SIZE = 8,
    parameter int NUM_BUFFERS    = 4,
    localparam int IDX_W = $clog2(FM_BUFFER_SIZE),
    localparam int BUF_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [BUF_W:0]   cfg_num_buf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUF_W-1:0] out_buf_sel,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last_idx,
    output logic             out_last_buf,
    output logic             finished_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FM_BUFFER_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [BUF_W-1:0] BUF_ONE = BUF_W'(1);
    localparam logic [BUF_W:0]   CFG_ONE = (BUF_W+1)'(1);
    localparam logic [BUF_W:0]   CFG_MAX = (BUF_W+1)'(NUM_BUFFERS);

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [BUF_W-1:0]   r_buf;
    logic [BUF_W:0]     r_cfg;
    logic               r_valid;
    logic               r_last_idx;
    logic               r_last_buf;
    logic               r_fin;
    logic               r_busy;
    logic               r_done;

    state_t             w_nxt_state;
    logic [IDX_W-1:0]   w_nxt_index;
    logic [BUF_W-1:0]   w_nxt_buf;
    logic [BUF_W:0]     w_nxt_cfg;
    logic               w_nxt_fin;
    logic               w_nxt_valid;
    logic               w_hs;
    logic               w_on_last_buf;
    logic [BUF_W:0]     w_cfg_clamped;

    // A zero or oversized buffer count means "scan every buffer".
    assign w_cfg_clamped = ((cfg_num_buf == '0) || (cfg_num_buf > CFG_MAX)) ? CFG_MAX : cfg_num_buf;
    assign w_hs          = r_valid & out_ready;
    assign w_on_last_buf = ({1'b0, r_buf} == (r_cfg - CFG_ONE));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_index = r_index;
        w_nxt_buf   = r_buf;
        w_nxt_cfg   = r_cfg;
        w_nxt_fin   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_nxt_cfg   = w_cfg_clamped;
                    w_nxt_state = ST_SCAN;
                    w_nxt_index = '0;
                    w_nxt_buf   = '0;
                end
            end
            ST_SCAN: begin
                if (w_hs) begin
                    if (r_index == IDX_MAX) begin
                        w_nxt_index = '0;
                        w_nxt_fin   = 1'b1;
                        if (w_on_last_buf) begin
                            w_nxt_state = ST_DONE;
                            w_nxt_buf   = '0;
                        end else begin
                            w_nxt_state = ST_GAP;
                            w_nxt_buf   = r_buf + BUF_ONE;
                        end
                    end else begin
                        w_nxt_index = r_index + IDX_ONE;
                    end
                end
            end
            ST_GAP:  w_nxt_state = ST_SCAN;
            ST_DONE: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
        // Abort drops the interrupted buffer without a completion pulse.
        if (abort) begin
            w_nxt_state = ST_IDLE;
            w_nxt_index = '0;
            w_nxt_buf   = '0;
            w_nxt_fin   = 1'b0;
        end
    end

    assign w_nxt_valid = (w_nxt_state == ST_SCAN);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_buf      <= '0;
            r_cfg      <= '0;
            r_valid    <= 1'b0;
            r_last_idx <= 1'b0;
            r_last_buf <= 1'b0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_index    <= w_nxt_index;
            r_buf      <= w_nxt_buf;
            r_cfg      <= w_nxt_cfg;
            r_valid    <= w_nxt_valid;
            r_last_idx <= w_nxt_valid && (w_nxt_index == IDX_MAX);
            r_last_buf <= w_nxt_valid && ({1'b0, w_nxt_buf} == (w_nxt_cfg - CFG_ONE));
            r_fin      <= w_nxt_fin;
            r_busy     <= (w_nxt_state == ST_SCAN) || (w_nxt_state == ST_GAP);
            r_done     <= (w_nxt_state == ST_DONE);
        end
    end

    assign out_valid      = r_valid;
    assign out_buf_sel    = r_buf;
    assign out_index      = r_index;
    assign out_last_idx   = r_last_idx;
    assign out_last_buf   = r_last_buf;
    assign finished_count = r_fin;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_proj_scan_ctrl.sv
// Directed bench for proj_scan_ctrl: scoreboard of expected beats plus per-cycle pulse/valid/busy model.
module tb_proj_scan_ctrl;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] cfg_num_buf = 3'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_buf_sel;
    logic [2:0] out_index;
    logic       out_last_idx;
    logic       out_last_buf;
    logic       finished_count;
    logic       busy;
    logic       done;

    proj_scan_ctrl #(.FM_BUFFER_SIZE(8), .NUM_BUFFERS(4)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .start(start), .abort(abort),
        .cfg_num_buf(cfg_num_buf), .out_valid(out_valid), .out_ready(out_ready),
        .out_buf_sel(out_buf_sel), .out_index(out_index), .out_last_idx(out_last_idx),
        .out_last_buf(out_last_buf), .finished_count(finished_count), .busy(busy), .done(done)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    // Beat encoding: {last_buf, last_idx, buf[1:0], idx[2:0]}
    logic [6:0] sb[$];
    int  fin_cyc[$];
    bit  scan_active = 1'b0;
    bit  fin_exp = 1'b0;
    bit  done_exp = 1'b0;
    bit  done_now = 1'b0;
    int  ncyc = 0;
    int  hs_cnt = 0;
    int  fin_cnt = 0;
    int  done_cnt = 0;
    int  start_cyc = 0;
    int  done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        @(negedge in_clk);
        ncyc++;
        check("finished_count", 32'(finished_count), 32'(fin_exp));
        check("done", 32'(done), 32'(done_exp));
        check("out_valid", 32'(out_valid), 32'(scan_active && !fin_exp));
        check("busy", 32'(busy), 32'(scan_active && !done_exp));
        if (finished_count) begin
            fin_cnt++;
            fin_cyc.push_back(ncyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        done_now = done_exp;
        if (done_exp) scan_active = 1'b0;
        fin_exp  = 1'b0;
        done_exp = 1'b0;
        if (out_valid) begin
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
                check("beat", 32'({out_last_buf, out_last_idx, out_buf_sel, out_index}), 32'(sb[0]));
        end
    endtask

    task automatic drive(input logic rdy, input logic st, input logic ab, input logic [2:0] cfg);
        logic [6:0] e;
        int n;
        out_ready   = rdy;
        start       = st;
        abort       = ab;
        cfg_num_buf = cfg;
        if (out_valid && rdy && (sb.size() != 0)) begin
            e = sb.pop_front();
            hs_cnt++;
            if (!ab && e[5]) begin
                fin_exp = 1'b1;
                if (e[6]) done_exp = 1'b1;
            end
        end
        if (ab) begin
            sb.delete();
            scan_active = 1'b0;
        end else if (st && !scan_active && !done_now) begin
            n = ((cfg == 3'd0) || (cfg > 3'd4)) ? 4 : int'(cfg);
            for (int b = 0; b < n; b++)
                for (int i = 0; i < 8; i++)
                    sb.push_back({(b == n - 1), (i == 7), 2'(b), 3'(i)});
            scan_active = 1'b1;
            start_cyc   = ncyc;
        end
        done_now = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            observe();
            drive(1'b1, 1'b0, 1'b0, 3'd0);
        end
    endtask

    task automatic run_scan(input logic [2:0] cfg, input bit rnd, input bit spam);
        int n, hs0, fin0, done0, k;
        bit got;
        logic rdy;
        n     = ((cfg == 3'd0) || (cfg > 3'd4)) ? 4 : int'(cfg);
        hs0   = hs_cnt;
        fin0  = fin_cnt;
        done0 = done_cnt;
        fin_cyc.delete();
        observe();
        drive(1'b1, 1'b1, 1'b0, cfg);
        k   = 0;
        got = 1'b0;
        while (!got && k < 600) begin
            observe();
            k++;
            if (done_now) got = 1'b1;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(rdy, spam, 1'b0, spam ? 3'd1 : cfg);
        end
        check("scan_done_reached", 32'(got), 32'd1);
        check("handshakes", 32'(hs_cnt - hs0), 32'(n * 8));
        check("fin_pulses", 32'(fin_cnt - fin0), 32'(n));
        check("done_pulses", 32'(done_cnt - done0), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int fin0, done0, k;
        bit aborted;
        logic ab;

        // Reset state
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_buf", 32'(out_buf_sel), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_last_idx", 32'(out_last_idx), 32'd0);
        check("rst_last_buf", 32'(out_last_buf), 32'd0);
        check("rst_fin", 32'(finished_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        idle_cycles(2);

        // Two buffers at full throughput, with exact pulse timing
        run_scan(3'd2, 1'b0, 1'b0);
        check("fin_cyc_count", 32'(fin_cyc.size()), 32'd2);
        if (fin_cyc.size() >= 2) begin
            check("fin0_cycle", 32'(fin_cyc[0] - start_cyc), 32'd9);
            check("fin1_cycle", 32'(fin_cyc[1] - start_cyc), 32'd18);
        end
        check("done_cycle", 32'(done_cyc - start_cyc), 32'd18);
        idle_cycles(2);

        // One buffer with random stalls
        run_scan(3'd1, 1'b1, 1'b0);
        idle_cycles(2);

        // Abort at buffer 1 index 3, accepted in the same cycle
        fin0  = fin_cnt;
        done0 = done_cnt;
        observe();
        drive(1'b1, 1'b1, 1'b0, 3'd2);
        k = 0;
        aborted = 1'b0;
        while (!aborted && k < 100) begin
            observe();
            k++;
            ab = out_valid && (out_buf_sel == 2'd1) && (out_index == 3'd3);
            drive(1'b1, 1'b0, ab, 3'd2);
            aborted = ab;
        end
        check("abort_reached", 32'(aborted), 32'd1);
        observe();
        check("abort_index", 32'(out_index), 32'd0);
        check("abort_buf", 32'(out_buf_sel), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        idle_cycles(3);
        check("abort_fin", 32'(fin_cnt - fin0), 32'd1);
        check("abort_no_done", 32'(done_cnt - done0), 32'd0);
        run_scan(3'd2, 1'b0, 1'b0);
        idle_cycles(1);

        // Clamping of zero and oversized counts
        run_scan(3'd0, 1'b0, 1'b0);
        idle_cycles(1);
        run_scan(3'd7, 1'b1, 1'b0);
        idle_cycles(1);

        // start while busy and in DONE ignored; start+abort in IDLE ignored
        run_scan(3'd2, 1'b0, 1'b1);
        check("spam_done_cycle", 32'(done_cyc - start_cyc), 32'd18);
        observe();
        drive(1'b1, 1'b1, 1'b1, 3'd2);
        idle_cycles(4);

        // Asynchronous reset in the middle of a scan
        observe();
        drive(1'b1, 1'b1, 1'b0, 3'd4);
        for (int c = 0; c < 5; c++) begin
            observe();
            drive(1'b1, 1'b0, 1'b0, 3'd4);
        end
        @(posedge in_clk);
        #2;
        in_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_buf", 32'(out_buf_sel), 32'd0);
        check("arst_index", 32'(out_index), 32'd0);
        check("arst_last", 32'({out_last_idx, out_last_buf}), 32'd0);
        check("arst_pulses", 32'({finished_count, done}), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        scan_active = 1'b0;
        fin_exp  = 1'b0;
        done_exp = 1'b0;
        done_now = 1'b0;
        start    = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        idle_cycles(2);
        run_scan(3'd3, 1'b0, 1'b0);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
